// File: rtl/memctrl_pkg.sv
// Shared definitions for the memory-controller host interface.
// Holds the FSM state encoding and the default geometry of the bus.
package memctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_RECOVER = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned AW_DEF     = 16;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned LAT_W      = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/memctrl_host.sv
// Single-outstanding request/response host for an SRAM-style memory controller.
// One ACCESS strobe cycle, one RECOVER cycle, optional WAIT cycles for read latency.
module memctrl_host
  import memctrl_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WR,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [DW-1:0] REQ_WDATA,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_RDATA,
  output logic [AW-1:0] ADDR,
  output logic          CE,
  output logic          CSB,
  output logic          WEB,
  output logic          OEB,
  output logic [DW-1:0] IDATA,
  input  logic [DW-1:0] ODATA
);

  state_t           r_state;
  logic             r_is_wr;
  logic [LAT_W-1:0] r_lat;
  logic [AW-1:0]    r_addr;
  logic             r_ce;
  logic             r_csb;
  logic             r_web;
  logic             r_oeb;
  logic [DW-1:0]    r_idata;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [DW-1:0]    r_rsp_rdata;

  state_t           w_state_nxt;
  logic             w_is_wr_nxt;
  logic [LAT_W-1:0] w_lat_nxt;
  logic             w_accept;
  logic             w_capture;
  logic [AW-1:0]    w_addr_nxt;
  logic             w_ce_nxt;
  logic             w_csb_nxt;
  logic             w_web_nxt;
  logic             w_oeb_nxt;
  logic [DW-1:0]    w_idata_nxt;
  logic             w_req_ready_nxt;
  logic             w_rsp_valid_nxt;
  logic [DW-1:0]    w_rsp_rdata_nxt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= ST_IDLE;
      r_is_wr     <= 1'b0;
      r_lat       <= '0;
      r_addr      <= '0;
      r_ce        <= 1'b0;
      r_csb       <= 1'b1;
      r_web       <= 1'b1;
      r_oeb       <= 1'b1;
      r_idata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_wr     <= w_is_wr_nxt;
      r_lat       <= w_lat_nxt;
      r_addr      <= w_addr_nxt;
      r_ce        <= w_ce_nxt;
      r_csb       <= w_csb_nxt;
      r_web       <= w_web_nxt;
      r_oeb       <= w_oeb_nxt;
      r_idata     <= w_idata_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_is_wr_nxt = r_is_wr;
    w_lat_nxt   = r_lat;
    w_capture   = 1'b0;
    w_accept    = (r_state == ST_IDLE) && r_req_ready && REQ_VALID;

    // RECOVER is the first post-ACCESS cycle for reads too, so WAIT only
    // covers the remaining RD_LAT-1 cycles before the capture edge.
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ACCESS;
          w_is_wr_nxt = REQ_WR;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RECOVER;
      ST_RECOVER: begin
        if (r_is_wr) begin
          w_state_nxt = ST_IDLE;
        end else if (RD_LAT <= 1) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
          w_lat_nxt   = LAT_W'(RD_LAT - 2);
        end
      end
      ST_WAIT: begin
        if (r_lat == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_lat_nxt = r_lat - 1'b1;
        end
      end
      ST_RESP: begin
        if (RSP_READY) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Strobes are driven only in the cycle following an accept (ACCESS).
    w_addr_nxt      = w_accept ? REQ_ADDR : r_addr;
    w_ce_nxt        = w_accept;
    w_csb_nxt       = !w_accept;
    w_web_nxt       = !(w_accept && REQ_WR);
    w_oeb_nxt       = !(w_accept && !REQ_WR);
    w_idata_nxt     = (w_accept && REQ_WR) ? REQ_WDATA : '0;
    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
    w_rsp_rdata_nxt = w_capture ? ODATA : r_rsp_rdata;
  end

  assign REQ_READY = r_req_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign ADDR      = r_addr;
  assign CE        = r_ce;
  assign CSB       = r_csb;
  assign WEB       = r_web;
  assign OEB       = r_oeb;
  assign IDATA     = r_idata;

endmodule
